lsu_ahb_buf: RTL and testbench
==============================

Name: lsu_ahb_buf

Overview:
- Decoupling buffer between the core LSU request/response port and the AHB-Lite master's LSU-side port in the SoC top.
- Registers LSU requests into a small in-order FIFO and AHB responses into a response FIFO.
- Limits outstanding transactions with a credit counter so the response FIFO can never overflow.
- Breaks the combinational valid/ready path between core and bus.

Parameters:
- REQ_DEPTH, 2, request FIFO entries (power of 2, >=2)
- RSP_DEPTH, 2, response FIFO entries (power of 2, >=2); also the maximum number of outstanding transactions
- TIMEOUT_CYC, 1024, bus response timeout in cycles (used only with the optional feature)

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- lsu_req_vld  in  1  core request valid
- lsu_req_rdy  out  1  buffer can accept a request
- lsu_req_wen  in  1  1 = write, 0 = read
- lsu_req_rwtyp  in  3  access type (funct3 encoding), passed through
- lsu_req_addr  in  32  byte address
- lsu_req_wdata  in  32  write data
- lsu_rsp_vld  out  1  response valid to core
- lsu_rsp_rdy  in  1  core accepts response
- lsu_rsp_rdata  out  32  response data
- ahbm_req_vld  out  1  request valid to AHB master
- ahbm_req_rdy  in  1  AHB master accepts request
- ahbm_req_wen  out  1  buffered wen
- ahbm_req_rwtyp  out  3  buffered rwtyp
- ahbm_req_addr  out  32  buffered address
- ahbm_req_wdata  out  32  buffered write data
- ahbm_rsp_vld  in  1  AHB response valid
- ahbm_rsp_rdy  out  1  buffer accepts AHB response
- ahbm_rsp_rdata  in  32  AHB response data
- credit_cnt  out  clog2(RSP_DEPTH)+1  transactions accepted from core and not yet returned to core
- timeout_err  out  1  sticky bus-timeout flag

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rstn. Reset flushes both FIFOs and zeroes all counters and flags.
- Reset values: lsu_req_rdy=0 while rstn low, otherwise 1. All valids 0, all data outputs 0, ahbm_rsp_rdy=1, credit_cnt=0, timeout_err=0.
- Handshake rule: a transfer occurs on a rising edge where vld & rdy. Valid, once raised, holds with stable payload until accepted; this applies to both block outputs.
- Transaction rule: every request, read or write, yields exactly one response. Responses are returned strictly in order; the write response carries ahbm_rsp_rdata unmodified.
- lsu_req_rdy = !req_full && (credit_cnt < RSP_DEPTH). It is a function of registered state only, with no combinational path from any vld.
- credit_cnt:
  - +1 on a core request handshake; -1 on a core response handshake.
  - Both in the same cycle: unchanged.
  - Never exceeds RSP_DEPTH and never underflows.
- Request FIFO:
  - ahbm_req_* driven from the head entry; ahbm_req_vld = !req_empty.
  - Push and pop in the same cycle allowed when not full/empty; occupancy unchanged.
  - No write-through: a request accepted at edge N appears on ahbm_req_* no earlier than after edge N, giving a minimum 1-cycle latency.
- Response FIFO:
  - ahbm_rsp_rdy = !rsp_full (always 1 by the credit rule; still implemented and asserted in verification).
  - lsu_rsp_vld = !rsp_empty; lsu_rsp_rdata = head entry.
  - Minimum AHB-response-to-core latency is 1 cycle.
- Pointers: binary, 1 bit wider than the index; full/empty from MSB compare; wrap-around modulo depth.
- ahb_pend counter (internal): +1 on an AHB request handshake, -1 on an AHB response handshake.
- A response while ahb_pend==0 is a protocol error; it is dropped, not pushed.
- Reset mid-transaction: all in-flight state is discarded; no response is replayed after reset.

Optional Feature:
- LSU_BUF_TIMEOUT_EN defined:
  - A timer counts cycles while ahb_pend>0. It clears on any AHB response handshake, and on an AHB request handshake when ahb_pend==0.
  - When the timer reaches TIMEOUT_CYC-1, the block pushes a synthetic response 32'hDEAD_BEEF into the response FIFO and sets timeout_err (sticky until reset).
  - The same expiry decrements ahb_pend, increments drop_cnt, and clears the timer.
  - While drop_cnt>0, arriving AHB responses are accepted (ahbm_rsp_rdy=1), discarded, and decrement drop_cnt.
  - Expiry and a real response in the same cycle: the real response wins and the timer clears.
- LSU_BUF_TIMEOUT_EN undefined: no timer or drop logic; timeout_err tied 0; the block waits indefinitely.

Test Plan:
- Single read: core read addr 0x1000_0004 at cycle 0 with ahbm_req_rdy=1, AHB returns rdata 0x1234_5678 at cycle 3 → ahbm_req_vld at cycle 1; lsu_rsp_vld at cycle 4 with 0x1234_5678; credit_cnt goes 0→1→0.
- Back-to-back with backpressure: 4 writes issued with ahbm_req_rdy=0 → after 2 accepts lsu_req_rdy=0 (credit limit 2). Release rdy → requests leave in order; responses return in order; credit_cnt never exceeds 2.
- Core stall: lsu_rsp_rdy=0 with 2 outstanding → rsp FIFO holds 2; ahbm_rsp_rdy stays 1; no request accepted until a core response handshake.
- Simultaneous events: with credit_cnt=1, request and response handshake in the same cycle → credit_cnt stays 1; both FIFOs consistent.
- Reset mid-operation: rstn low for 1 cycle with 2 entries queued → all valids 0 and credit_cnt=0 immediately (asynchronously); no stale response after release.
- Timeout (LSU_BUF_TIMEOUT_EN, TIMEOUT_CYC=16): AHB never responds → after 16 cycles lsu_rsp_rdata=0xDEAD_BEEF and timeout_err=1. A late AHB response is accepted and not forwarded.

Source files
------------

// File: rtl/lsu_ahb_buf.sv
// lsu_ahb_buf
//   Decoupling buffer between the core LSU request/response port and the
//   LSU-side port of the AHB-Lite master. Requests go through an in-order
//   request FIFO and bus responses through a response FIFO. A credit counter
//   bounds the number of transactions in flight so the response FIFO can
//   never overflow. Every core-facing and bus-facing valid/ready is a
//   function of registered state, which breaks the combinational path
//   between core and bus.
//
//   Optional feature (compile macro LSU_BUF_TIMEOUT_EN):
//     A bus response timer. On expiry a synthetic 32'hDEAD_BEEF response is
//     returned to the core, timeout_err is set (sticky), and the late bus
//     response is swallowed when it eventually arrives. Without the macro,
//     timeout_err is tied to 0 and the block waits indefinitely.
//
// Parameters
//   REQ_DEPTH    request FIFO entries (power of 2, >= 2)
//   RSP_DEPTH    response FIFO entries (power of 2, >= 2); max outstanding
//   TIMEOUT_CYC  bus response timeout in cycles (timeout build only)
//
// Ports
//   clk, rstn                 clock, asynchronous active-low reset
//   lsu_req_*                 core request in (vld/rdy, wen, rwtyp, addr, wdata)
//   lsu_rsp_*                 core response out (vld/rdy, rdata)
//   ahbm_req_*                request out to AHB master (head of request FIFO)
//   ahbm_rsp_*                response in from AHB master
//   credit_cnt                transactions accepted from core, not yet returned
//   timeout_err               sticky bus-timeout flag
module lsu_ahb_buf #(
  parameter int REQ_DEPTH   = 2,
  parameter int RSP_DEPTH   = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         lsu_req_vld,
  output logic                         lsu_req_rdy,
  input  logic                         lsu_req_wen,
  input  logic [2:0]                   lsu_req_rwtyp,
  input  logic [31:0]                  lsu_req_addr,
  input  logic [31:0]                  lsu_req_wdata,
  output logic                         lsu_rsp_vld,
  input  logic                         lsu_rsp_rdy,
  output logic [31:0]                  lsu_rsp_rdata,
  output logic                         ahbm_req_vld,
  input  logic                         ahbm_req_rdy,
  output logic                         ahbm_req_wen,
  output logic [2:0]                   ahbm_req_rwtyp,
  output logic [31:0]                  ahbm_req_addr,
  output logic [31:0]                  ahbm_req_wdata,
  input  logic                         ahbm_rsp_vld,
  output logic                         ahbm_rsp_rdy,
  input  logic [31:0]                  ahbm_rsp_rdata,
  output logic [$clog2(RSP_DEPTH):0]   credit_cnt,
  output logic                         timeout_err
);

  localparam int QAW = $clog2(REQ_DEPTH);
  localparam int SAW = $clog2(RSP_DEPTH);
  localparam int CW  = SAW + 1;
  localparam logic [CW-1:0] CRED_MAX = CW'(RSP_DEPTH);

  typedef struct packed {
    logic        wen;
    logic [2:0]  rwtyp;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  // ---------------------------------------------------------------------------
  // Request FIFO
  // ---------------------------------------------------------------------------
  req_t         req_mem [REQ_DEPTH];
  logic [QAW:0] req_wptr, req_rptr;
  logic         req_full, req_empty;
  logic         lsu_req_hs, ahbm_req_hs;
  req_t         req_head;

  assign req_empty = (req_wptr == req_rptr);
  assign req_full  = (req_wptr[QAW] != req_rptr[QAW]) &&
                     (req_wptr[QAW-1:0] == req_rptr[QAW-1:0]);

  // rstn gates ready so the core sees "not ready" for the whole reset pulse.
  assign lsu_req_rdy = rstn && !req_full && (credit_cnt < CRED_MAX);
  assign lsu_req_hs  = lsu_req_vld && lsu_req_rdy;
  assign ahbm_req_hs = ahbm_req_vld && ahbm_req_rdy;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      req_wptr <= '0;
      req_rptr <= '0;
      // NOTE: the storage is reset so every data output reads 0 out of reset;
      // with only a few entries this is cheap. Deep FIFOs normally skip this.
      for (int i = 0; i < REQ_DEPTH; i++) req_mem[i] <= '0;
    end else begin
      // NOTE: state is always updated with <=, so every process sees the
      // pre-edge value of every register regardless of statement order.
      if (lsu_req_hs) begin
        req_mem[req_wptr[QAW-1:0]] <= '{wen:   lsu_req_wen,   rwtyp: lsu_req_rwtyp,
                                        addr:  lsu_req_addr,  wdata: lsu_req_wdata};
        req_wptr <= req_wptr + (QAW+1)'(1);
      end
      if (ahbm_req_hs) req_rptr <= req_rptr + (QAW+1)'(1);
    end
  end

  assign req_head       = req_mem[req_rptr[QAW-1:0]];
  assign ahbm_req_vld   = !req_empty;
  assign ahbm_req_wen   = req_head.wen;
  assign ahbm_req_rwtyp = req_head.rwtyp;
  assign ahbm_req_addr  = req_head.addr;
  assign ahbm_req_wdata = req_head.wdata;

  // ---------------------------------------------------------------------------
  // Response FIFO
  // ---------------------------------------------------------------------------
  logic [31:0]  rsp_mem [RSP_DEPTH];
  logic [SAW:0] rsp_wptr, rsp_rptr;
  logic         rsp_full, rsp_empty;
  logic         rsp_push, rsp_pop;
  logic [31:0]  rsp_push_data;

  assign rsp_empty = (rsp_wptr == rsp_rptr);
  assign rsp_full  = (rsp_wptr[SAW] != rsp_rptr[SAW]) &&
                     (rsp_wptr[SAW-1:0] == rsp_rptr[SAW-1:0]);
  assign rsp_pop   = lsu_rsp_vld && lsu_rsp_rdy;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rsp_wptr <= '0;
      rsp_rptr <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) rsp_mem[i] <= '0;
    end else begin
      if (rsp_push) begin
        rsp_mem[rsp_wptr[SAW-1:0]] <= rsp_push_data;
        rsp_wptr <= rsp_wptr + (SAW+1)'(1);
      end
      if (rsp_pop) rsp_rptr <= rsp_rptr + (SAW+1)'(1);
    end
  end

  assign lsu_rsp_vld   = !rsp_empty;
  assign lsu_rsp_rdata = rsp_mem[rsp_rptr[SAW-1:0]];

  // ---------------------------------------------------------------------------
  // Credit and bus-pending counters
  // ---------------------------------------------------------------------------
  logic [CW-1:0] ahb_pend;
  logic          ahbm_rsp_hs, pend_nz, pend_dec;

  assign ahbm_rsp_hs = ahbm_rsp_vld && ahbm_rsp_rdy;
  assign pend_nz     = (ahb_pend != '0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      credit_cnt <= '0;
      ahb_pend   <= '0;
    end else begin
      case ({lsu_req_hs, rsp_pop})
        2'b10:   credit_cnt <= credit_cnt + CW'(1);
        2'b01:   credit_cnt <= credit_cnt - CW'(1);
        default: credit_cnt <= credit_cnt;
      endcase
      case ({ahbm_req_hs, pend_dec})
        2'b10:   ahb_pend <= ahb_pend + CW'(1);
        2'b01:   ahb_pend <= ahb_pend - CW'(1);
        default: ahb_pend <= ahb_pend;
      endcase
    end
  end

`ifdef LSU_BUF_TIMEOUT_EN
  // ---------------------------------------------------------------------------
  // Bus response timeout
  // ---------------------------------------------------------------------------
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] timer;
  // Counts responses still owed by the bus for transactions already answered
  // synthetically; wide enough for many back-to-back timeouts.
  logic [7:0]    drop_cnt;
  logic          drop_nz, rsp_fwd, expire, err_q;

  assign drop_nz = (drop_cnt != '0);
  // While late responses are owed they are always accepted, even if full.
  assign ahbm_rsp_rdy = !rsp_full || drop_nz;
  assign rsp_fwd      = ahbm_rsp_hs && !drop_nz && pend_nz;
  // A real response in the expiry cycle wins.
  assign expire        = pend_nz && !ahbm_rsp_hs && (timer == TMAX);
  assign rsp_push      = rsp_fwd || expire;
  assign rsp_push_data = expire ? 32'hDEAD_BEEF : ahbm_rsp_rdata;
  assign pend_dec      = rsp_fwd || expire;
  assign timeout_err   = err_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      timer    <= '0;
      drop_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (ahbm_rsp_hs || (ahbm_req_hs && !pend_nz) || expire) timer <= '0;
      else if (pend_nz)                                       timer <= timer + TW'(1);

      if (expire)                      drop_cnt <= drop_cnt + 8'd1;
      else if (ahbm_rsp_hs && drop_nz) drop_cnt <= drop_cnt - 8'd1;

      if (expire) err_q <= 1'b1;
    end
  end
`else
  // Responses arriving with nothing pending are protocol errors and dropped.
  assign ahbm_rsp_rdy  = !rsp_full;
  assign rsp_push      = ahbm_rsp_hs && pend_nz;
  assign rsp_push_data = ahbm_rsp_rdata;
  assign pend_dec      = rsp_push;
  assign timeout_err   = 1'b0;

  // TIMEOUT_CYC only matters to the timeout build.
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = (TIMEOUT_CYC != 0);
`endif

endmodule

// File: tb/tb_lsu_ahb_buf.sv
module tb_lsu_ahb_buf;

  logic        clk = 1'b0;
  logic        rstn;
  logic        lsu_req_vld, lsu_req_rdy, lsu_req_wen;
  logic [2:0]  lsu_req_rwtyp;
  logic [31:0] lsu_req_addr, lsu_req_wdata;
  logic        lsu_rsp_vld, lsu_rsp_rdy;
  logic [31:0] lsu_rsp_rdata;
  logic        ahbm_req_vld, ahbm_req_rdy, ahbm_req_wen;
  logic [2:0]  ahbm_req_rwtyp;
  logic [31:0] ahbm_req_addr, ahbm_req_wdata;
  logic        ahbm_rsp_vld, ahbm_rsp_rdy;
  logic [31:0] ahbm_rsp_rdata;
  logic [1:0]  credit_cnt;
  logic        timeout_err;

  int errors = 0;
  int checks = 0;

  lsu_ahb_buf #(.REQ_DEPTH(2), .RSP_DEPTH(2), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rstn(rstn),
    .lsu_req_vld(lsu_req_vld), .lsu_req_rdy(lsu_req_rdy), .lsu_req_wen(lsu_req_wen),
    .lsu_req_rwtyp(lsu_req_rwtyp), .lsu_req_addr(lsu_req_addr), .lsu_req_wdata(lsu_req_wdata),
    .lsu_rsp_vld(lsu_rsp_vld), .lsu_rsp_rdy(lsu_rsp_rdy), .lsu_rsp_rdata(lsu_rsp_rdata),
    .ahbm_req_vld(ahbm_req_vld), .ahbm_req_rdy(ahbm_req_rdy), .ahbm_req_wen(ahbm_req_wen),
    .ahbm_req_rwtyp(ahbm_req_rwtyp), .ahbm_req_addr(ahbm_req_addr), .ahbm_req_wdata(ahbm_req_wdata),
    .ahbm_rsp_vld(ahbm_rsp_vld), .ahbm_rsp_rdy(ahbm_rsp_rdy), .ahbm_rsp_rdata(ahbm_rsp_rdata),
    .credit_cnt(credit_cnt), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge, away from the
  // rising edge where the DUT transfers.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic idle();
    lsu_req_vld    = 1'b0;
    lsu_req_wen    = 1'b0;
    lsu_req_rwtyp  = 3'b000;
    lsu_req_addr   = 32'h0;
    lsu_req_wdata  = 32'h0;
    lsu_rsp_rdy    = 1'b0;
    ahbm_req_rdy   = 1'b0;
    ahbm_rsp_vld   = 1'b0;
    ahbm_rsp_rdata = 32'h0;
  endtask

  task automatic test_reset();
    idle();
    rstn = 1'b0;
    lsu_req_vld = 1'b1;
    #3;
    checks++; if (lsu_req_rdy !== 1'b0) begin errors++; $display("FAIL rst_lsu_req_rdy: got %b want 0", lsu_req_rdy); end
    checks++; if (ahbm_req_vld !== 1'b0) begin errors++; $display("FAIL rst_ahbm_req_vld: got %b want 0", ahbm_req_vld); end
    checks++; if (lsu_rsp_vld !== 1'b0) begin errors++; $display("FAIL rst_lsu_rsp_vld: got %b want 0", lsu_rsp_vld); end
    checks++; if (ahbm_rsp_rdy !== 1'b1) begin errors++; $display("FAIL rst_ahbm_rsp_rdy: got %b want 1", ahbm_rsp_rdy); end
    checks++; if (credit_cnt !== 2'd0) begin errors++; $display("FAIL rst_credit: got %0d want 0", credit_cnt); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL rst_timeout_err: got %b want 0", timeout_err); end
    checks++; if ({ahbm_req_wen, ahbm_req_rwtyp, ahbm_req_addr, ahbm_req_wdata} !== 68'h0) begin
      errors++; $display("FAIL rst_ahbm_req_data: got addr %h wdata %h want 0", ahbm_req_addr, ahbm_req_wdata);
    end
    checks++; if (lsu_rsp_rdata !== 32'h0) begin errors++; $display("FAIL rst_lsu_rsp_rdata: got %h want 0", lsu_rsp_rdata); end
    lsu_req_vld = 1'b0;
    cyc();
    rstn = 1'b1;
    cyc();
    checks++; if (lsu_req_rdy !== 1'b1) begin errors++; $display("FAIL rst_release_rdy: got %b want 1", lsu_req_rdy); end
  endtask

  task automatic test_single_read();
    // cycle 0: core read
    lsu_req_vld = 1'b1; lsu_req_wen = 1'b0; lsu_req_rwtyp = 3'b010;
    lsu_req_addr = 32'h1000_0004; ahbm_req_rdy = 1'b1;
    checks++; if (lsu_req_rdy !== 1'b1) begin errors++; $display("FAIL rd_req_rdy: got %b want 1", lsu_req_rdy); end
    cyc(); // cycle 1
    lsu_req_vld = 1'b0;
    checks++; if (ahbm_req_vld !== 1'b1) begin errors++; $display("FAIL rd_ahbm_vld_c1: got %b want 1", ahbm_req_vld); end
    checks++; if (ahbm_req_addr !== 32'h1000_0004) begin errors++; $display("FAIL rd_ahbm_addr: got %h want 10000004", ahbm_req_addr); end
    checks++; if ({ahbm_req_wen, ahbm_req_rwtyp} !== 4'b0010) begin errors++; $display("FAIL rd_ahbm_wen_typ: got %b want 0010", {ahbm_req_wen, ahbm_req_rwtyp}); end
    checks++; if (credit_cnt !== 2'd1) begin errors++; $display("FAIL rd_credit_c1: got %0d want 1", credit_cnt); end
    cyc(); // cycle 2
    checks++; if (ahbm_req_vld !== 1'b0) begin errors++; $display("FAIL rd_ahbm_vld_c2: got %b want 0", ahbm_req_vld); end
    cyc(); // cycle 3: bus answers
    ahbm_rsp_vld = 1'b1; ahbm_rsp_rdata = 32'h1234_5678;
    checks++; if (ahbm_rsp_rdy !== 1'b1) begin errors++; $display("FAIL rd_ahbm_rsp_rdy: got %b want 1", ahbm_rsp_rdy); end
    checks++; if (lsu_rsp_vld !== 1'b0) begin errors++; $display("FAIL rd_rsp_vld_c3: got %b want 0", lsu_rsp_vld); end
    cyc(); // cycle 4
    ahbm_rsp_vld = 1'b0; lsu_rsp_rdy = 1'b1;
    checks++; if (lsu_rsp_vld !== 1'b1) begin errors++; $display("FAIL rd_rsp_vld_c4: got %b want 1", lsu_rsp_vld); end
    checks++; if (lsu_rsp_rdata !== 32'h1234_5678) begin errors++; $display("FAIL rd_rsp_rdata: got %h want 12345678", lsu_rsp_rdata); end
    checks++; if (credit_cnt !== 2'd1) begin errors++; $display("FAIL rd_credit_c4: got %0d want 1", credit_cnt); end
    cyc(); // cycle 5
    lsu_rsp_rdy = 1'b0; ahbm_req_rdy = 1'b0;
    checks++; if (lsu_rsp_vld !== 1'b0) begin errors++; $display("FAIL rd_rsp_vld_c5: got %b want 0", lsu_rsp_vld); end
    checks++; if (credit_cnt !== 2'd0) begin errors++; $display("FAIL rd_credit_c5: got %0d want 0", credit_cnt); end
  endtask

  // Four writes against a stalled bus; also covers a request handshake and a
  // response handshake landing on the same edge with credit_cnt=1.
  task automatic test_back_to_back();
    logic [31:0] a [4];
    logic [31:0] d [4];
    logic [31:0] r [4];
    a = '{32'h2000_0000, 32'h2000_0004, 32'h2000_0008, 32'h2000_000C};
    d = '{32'hA0A0_0000, 32'hA1A1_1111, 32'hA2A2_2222, 32'hA3A3_3333};
    r = '{32'h0000_00F0, 32'h0000_00F1, 32'h0000_00F2, 32'h0000_00F3};
    lsu_req_wen = 1'b1; lsu_req_rwtyp = 3'b010;
    // N0
    lsu_req_vld = 1'b1; lsu_req_addr = a[0]; lsu_req_wdata = d[0];
    checks++; if (lsu_req_rdy !== 1'b1) begin errors++; $display("FAIL b2b_rdy_n0: got %b want 1", lsu_req_rdy); end
    cyc(); // N1
    lsu_req_addr = a[1]; lsu_req_wdata = d[1];
    checks++; if (lsu_req_rdy !== 1'b1) begin errors++; $display("FAIL b2b_rdy_n1: got %b want 1", lsu_req_rdy); end
    checks++; if (credit_cnt !== 2'd1) begin errors++; $display("FAIL b2b_credit_n1: got %0d want 1", credit_cnt); end
    cyc(); // N2: credit limit reached
    lsu_req_addr = a[2]; lsu_req_wdata = d[2];
    checks++; if (lsu_req_rdy !== 1'b0) begin errors++; $display("FAIL b2b_rdy_limit: got %b want 0", lsu_req_rdy); end
    checks++; if (credit_cnt !== 2'd2) begin errors++; $display("FAIL b2b_credit_n2: got %0d want 2", credit_cnt); end
    checks++; if ({ahbm_req_vld, ahbm_req_wen} !== 2'b11) begin errors++; $display("FAIL b2b_ahbm_vld_wen: got %b want 11", {ahbm_req_vld, ahbm_req_wen}); end
    checks++; if ({ahbm_req_addr, ahbm_req_wdata} !== {a[0], d[0]}) begin errors++; $display("FAIL b2b_head0: got %h/%h want %h/%h", ahbm_req_addr, ahbm_req_wdata, a[0], d[0]); end
    cyc(); // N3: still stalled, payload stable
    ahbm_req_rdy = 1'b1;
    checks++; if (lsu_req_rdy !== 1'b0) begin errors++; $display("FAIL b2b_rdy_n3: got %b want 0", lsu_req_rdy); end
    checks++; if (ahbm_req_addr !== a[0]) begin errors++; $display("FAIL b2b_head0_stable: got %h want %h", ahbm_req_addr, a[0]); end
    cyc(); // N4
    checks++; if ({ahbm_req_addr, ahbm_req_wdata} !== {a[1], d[1]}) begin errors++; $display("FAIL b2b_head1: got %h/%h want %h/%h", ahbm_req_addr, ahbm_req_wdata, a[1], d[1]); end
    checks++; if (lsu_req_rdy !== 1'b0) begin errors++; $display("FAIL b2b_rdy_n4: got %b want 0", lsu_req_rdy); end
    cyc(); // N5
    ahbm_req_rdy = 1'b0;
    checks++; if (ahbm_req_vld !== 1'b0) begin errors++; $display("FAIL b2b_drained: got %b want 0", ahbm_req_vld); end
    ahbm_rsp_vld = 1'b1; ahbm_rsp_rdata = r[0]; lsu_rsp_rdy = 1'b1;
    cyc(); // N6
    ahbm_rsp_rdata = r[1];
    checks++; if ({lsu_rsp_vld, lsu_rsp_rdata} !== {1'b1, r[0]}) begin errors++; $display("FAIL b2b_rsp0: got %b/%h want 1/%h", lsu_rsp_vld, lsu_rsp_rdata, r[0]); end
    checks++; if (credit_cnt !== 2'd2) begin errors++; $display("FAIL b2b_credit_n6: got %0d want 2", credit_cnt); end
    cyc(); // N7: request and response handshake on the coming edge
    ahbm_rsp_vld = 1'b0;
    checks++; if (lsu_rsp_rdata !== r[1]) begin errors++; $display("FAIL b2b_rsp1: got %h want %h", lsu_rsp_rdata, r[1]); end
    checks++; if (credit_cnt !== 2'd1) begin errors++; $display("FAIL b2b_credit_n7: got %0d want 1", credit_cnt); end
    checks++; if (lsu_req_rdy !== 1'b1) begin errors++; $display("FAIL b2b_rdy_n7: got %b want 1", lsu_req_rdy); end
    cyc(); // N8
    checks++; if (credit_cnt !== 2'd1) begin errors++; $display("FAIL sim_credit_hold: got %0d want 1", credit_cnt); end
    checks++; if (lsu_rsp_vld !== 1'b0) begin errors++; $display("FAIL sim_rsp_empty: got %b want 0", lsu_rsp_vld); end
    checks++; if ({ahbm_req_vld, ahbm_req_addr} !== {1'b1, a[2]}) begin errors++; $display("FAIL sim_head2: got %b/%h want 1/%h", ahbm_req_vld, ahbm_req_addr, a[2]); end
    lsu_req_addr = a[3]; lsu_req_wdata = d[3]; ahbm_req_rdy = 1'b1;
    checks++; if (lsu_req_rdy !== 1'b1) begin errors++; $display("FAIL b2b_rdy_n8: got %b want 1", lsu_req_rdy); end
    cyc(); // N9
    lsu_req_vld = 1'b0;
    checks++; if (credit_cnt !== 2'd2) begin errors++; $display("FAIL b2b_credit_n9: got %0d want 2", credit_cnt); end
    checks++; if ({ahbm_req_addr, ahbm_req_wdata} !== {a[3], d[3]}) begin errors++; $display("FAIL b2b_head3: got %h/%h want %h/%h", ahbm_req_addr, ahbm_req_wdata, a[3], d[3]); end
    cyc(); // N10
    ahbm_req_rdy = 1'b0;
    checks++; if (ahbm_req_vld !== 1'b0) begin errors++; $display("FAIL b2b_drained2: got %b want 0", ahbm_req_vld); end
    ahbm_rsp_vld = 1'b1; ahbm_rsp_rdata = r[2];
    cyc(); // N11
    ahbm_rsp_rdata = r[3];
    checks++; if (lsu_rsp_rdata !== r[2]) begin errors++; $display("FAIL b2b_rsp2: got %h want %h", lsu_rsp_rdata, r[2]); end
    cyc(); // N12
    ahbm_rsp_vld = 1'b0;
    checks++; if (lsu_rsp_rdata !== r[3]) begin errors++; $display("FAIL b2b_rsp3: got %h want %h", lsu_rsp_rdata, r[3]); end
    checks++; if (credit_cnt !== 2'd1) begin errors++; $display("FAIL b2b_credit_n12: got %0d want 1", credit_cnt); end
    cyc(); // N13
    lsu_rsp_rdy = 1'b0;
    checks++; if ({lsu_rsp_vld, credit_cnt} !== 3'b000) begin errors++; $display("FAIL b2b_done: got vld %b credit %0d want 0/0", lsu_rsp_vld, credit_cnt); end
    idle();
  endtask

  task automatic test_core_stall();
    ahbm_req_rdy = 1'b1; lsu_req_wen = 1'b0; lsu_req_rwtyp = 3'b100;
    // N0
    lsu_req_vld = 1'b1; lsu_req_addr = 32'h3000_0000;
    cyc(); // N1
    lsu_req_addr = 32'h3000_0010;
    checks++; if ({ahbm_req_vld, ahbm_req_addr} !== {1'b1, 32'h3000_0000}) begin errors++; $display("FAIL stall_head_a: got %b/%h want 1/30000000", ahbm_req_vld, ahbm_req_addr); end
    cyc(); // N2
    lsu_req_vld = 1'b0;
    checks++; if (ahbm_req_addr !== 32'h3000_0010) begin errors++; $display("FAIL stall_head_b: got %h want 30000010", ahbm_req_addr); end
    checks++; if (lsu_req_rdy !== 1'b0) begin errors++; $display("FAIL stall_rdy_n2: got %b want 0", lsu_req_rdy); end
    cyc(); // N3
    ahbm_rsp_vld = 1'b1; ahbm_rsp_rdata = 32'h0000_AAAA;
    checks++; if (ahbm_rsp_rdy !== 1'b1) begin errors++; $display("FAIL stall_ahbm_rsp_rdy_x: got %b want 1", ahbm_rsp_rdy); end
    cyc(); // N4
    ahbm_rsp_rdata = 32'h0000_BBBB;
    checks++; if (ahbm_rsp_rdy !== 1'b1) begin errors++; $display("FAIL stall_ahbm_rsp_rdy_y: got %b want 1", ahbm_rsp_rdy); end
    checks++; if (lsu_rsp_rdata !== 32'h0000_AAAA) begin errors++; $display("FAIL stall_rsp_x: got %h want 0000aaaa", lsu_rsp_rdata); end
    cyc(); // N5: core still stalled, new request offered
    ahbm_rsp_vld = 1'b0;
    lsu_req_vld = 1'b1; lsu_req_addr = 32'h3000_0020;
    checks++; if ({lsu_rsp_vld, lsu_rsp_rdata} !== {1'b1, 32'h0000_AAAA}) begin errors++; $display("FAIL stall_rsp_hold: got %b/%h want 1/0000aaaa", lsu_rsp_vld, lsu_rsp_rdata); end
    checks++; if ({lsu_req_rdy, credit_cnt} !== 3'b010) begin errors++; $display("FAIL stall_blocked: got rdy %b credit %0d want 0/2", lsu_req_rdy, credit_cnt); end
    cyc(); // N6
    checks++; if ({lsu_req_rdy, ahbm_req_vld} !== 2'b00) begin errors++; $display("FAIL stall_no_accept: got rdy %b ahbm_vld %b want 0/0", lsu_req_rdy, ahbm_req_vld); end
    lsu_rsp_rdy = 1'b1;
    cyc(); // N7
    lsu_rsp_rdy = 1'b0;
    checks++; if (lsu_rsp_rdata !== 32'h0000_BBBB) begin errors++; $display("FAIL stall_rsp_y: got %h want 0000bbbb", lsu_rsp_rdata); end
    checks++; if ({lsu_req_rdy, credit_cnt} !== 3'b101) begin errors++; $display("FAIL stall_release: got rdy %b credit %0d want 1/1", lsu_req_rdy, credit_cnt); end
    cyc(); // N8
    lsu_req_vld = 1'b0;
    checks++; if ({ahbm_req_vld, ahbm_req_addr} !== {1'b1, 32'h3000_0020}) begin errors++; $display("FAIL stall_head_c: got %b/%h want 1/30000020", ahbm_req_vld, ahbm_req_addr); end
    checks++; if (credit_cnt !== 2'd2) begin errors++; $display("FAIL stall_credit_n8: got %0d want 2", credit_cnt); end
    cyc(); // N9
    ahbm_rsp_vld = 1'b1; ahbm_rsp_rdata = 32'h0000_CCCC; lsu_rsp_rdy = 1'b1;
    cyc(); // N10
    ahbm_rsp_vld = 1'b0;
    checks++; if (lsu_rsp_rdata !== 32'h0000_CCCC) begin errors++; $display("FAIL stall_rsp_z: got %h want 0000cccc", lsu_rsp_rdata); end
    cyc(); // N11
    lsu_rsp_rdy = 1'b0;
    checks++; if ({lsu_rsp_vld, credit_cnt} !== 3'b000) begin errors++; $display("FAIL stall_done: got vld %b credit %0d want 0/0", lsu_rsp_vld, credit_cnt); end
    idle();
  endtask

  task automatic test_reset_mid();
    lsu_req_vld = 1'b1; lsu_req_addr = 32'h4000_0000; // N0
    cyc();
    lsu_req_addr = 32'h4000_0004; // N1
    cyc();
    lsu_req_vld = 1'b0; // N2
    checks++; if ({ahbm_req_vld, credit_cnt} !== 3'b110) begin errors++; $display("FAIL rmid_queued: got vld %b credit %0d want 1/2", ahbm_req_vld, credit_cnt); end
    #2 rstn = 1'b0;
    #1;
    checks++; if ({ahbm_req_vld, lsu_rsp_vld, lsu_req_rdy} !== 3'b000) begin errors++; $display("FAIL rmid_async_vld: got %b want 000", {ahbm_req_vld, lsu_rsp_vld, lsu_req_rdy}); end
    checks++; if (credit_cnt !== 2'd0) begin errors++; $display("FAIL rmid_async_credit: got %0d want 0", credit_cnt); end
    checks++; if (ahbm_req_addr !== 32'h0) begin errors++; $display("FAIL rmid_async_addr: got %h want 0", ahbm_req_addr); end
    cyc(); // N3: release, bus delivers a stale response
    rstn = 1'b1;
    ahbm_req_rdy = 1'b1; ahbm_rsp_vld = 1'b1; ahbm_rsp_rdata = 32'hBAD0_0001;
    cyc(); // N4
    ahbm_rsp_vld = 1'b0;
    checks++; if ({lsu_req_rdy, ahbm_req_vld, lsu_rsp_vld} !== 3'b100) begin errors++; $display("FAIL rmid_after: got %b want 100", {lsu_req_rdy, ahbm_req_vld, lsu_rsp_vld}); end
    checks++; if (credit_cnt !== 2'd0) begin errors++; $display("FAIL rmid_after_credit: got %0d want 0", credit_cnt); end
    cyc(); // N5
    checks++; if (lsu_rsp_vld !== 1'b0) begin errors++; $display("FAIL rmid_no_stale: got %b want 0", lsu_rsp_vld); end
    idle();
  endtask

`ifdef LSU_BUF_TIMEOUT_EN
  task automatic test_timeout();
    ahbm_req_rdy = 1'b1; lsu_req_vld = 1'b1; lsu_req_addr = 32'h5000_0000; // N0
    cyc(); // N1
    lsu_req_vld = 1'b0;
    checks++; if (ahbm_req_vld !== 1'b1) begin errors++; $display("FAIL to_issue: got %b want 1", ahbm_req_vld); end
    repeat (16) cyc(); // N17
    checks++; if ({lsu_rsp_vld, timeout_err} !== 2'b00) begin errors++; $display("FAIL to_early: got vld %b err %b want 0/0", lsu_rsp_vld, timeout_err); end
    cyc(); // N18
    checks++; if ({lsu_rsp_vld, lsu_rsp_rdata} !== {1'b1, 32'hDEAD_BEEF}) begin errors++; $display("FAIL to_synth: got %b/%h want 1/deadbeef", lsu_rsp_vld, lsu_rsp_rdata); end
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_err_set: got %b want 1", timeout_err); end
    lsu_rsp_rdy = 1'b1;
    cyc(); // N19: late bus response
    lsu_rsp_rdy = 1'b0;
    ahbm_rsp_vld = 1'b1; ahbm_rsp_rdata = 32'h5555_AAAA;
    checks++; if (ahbm_rsp_rdy !== 1'b1) begin errors++; $display("FAIL to_late_rdy: got %b want 1", ahbm_rsp_rdy); end
    checks++; if (credit_cnt !== 2'd0) begin errors++; $display("FAIL to_credit: got %0d want 0", credit_cnt); end
    cyc(); // N20
    ahbm_rsp_vld = 1'b0;
    checks++; if ({lsu_rsp_vld, timeout_err} !== 2'b01) begin errors++; $display("FAIL to_late_dropped: got vld %b err %b want 0/1", lsu_rsp_vld, timeout_err); end
    cyc(); // N21
    checks++; if (lsu_rsp_vld !== 1'b0) begin errors++; $display("FAIL to_late_quiet: got %b want 0", lsu_rsp_vld); end
    idle();
  endtask
`else
  task automatic test_no_timeout();
    ahbm_req_rdy = 1'b1; lsu_req_vld = 1'b1; lsu_req_addr = 32'h5000_0000; // N0
    cyc();
    lsu_req_vld = 1'b0; // N1
    repeat (20) cyc(); // N21
    checks++; if ({lsu_rsp_vld, timeout_err, credit_cnt} !== 4'b0001) begin errors++; $display("FAIL nto_wait: got vld %b err %b credit %0d want 0/0/1", lsu_rsp_vld, timeout_err, credit_cnt); end
    ahbm_rsp_vld = 1'b1; ahbm_rsp_rdata = 32'hCAFE_F00D;
    cyc(); // N22
    ahbm_rsp_vld = 1'b0; lsu_rsp_rdy = 1'b1;
    checks++; if ({lsu_rsp_vld, lsu_rsp_rdata} !== {1'b1, 32'hCAFE_F00D}) begin errors++; $display("FAIL nto_rsp: got %b/%h want 1/cafef00d", lsu_rsp_vld, lsu_rsp_rdata); end
    cyc(); // N23
    lsu_rsp_rdy = 1'b0;
    checks++; if ({lsu_rsp_vld, credit_cnt} !== 3'b000) begin errors++; $display("FAIL nto_done: got vld %b credit %0d want 0/0", lsu_rsp_vld, credit_cnt); end
    idle();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_read();
    test_back_to_back();
    test_core_stall();
    test_reset_mid();
`ifdef LSU_BUF_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
